// File: rtl/fifo_arb_pkg.sv
// Shared types and limits for the FIFO write arbiter.
// Burst locking is enabled by defining FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_REQ = 16;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// One-hot round-robin selector.
// First set bit of valid at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Upward search from ptr, modulo N
  always_comb begin : search
    logic          found;
    logic [IW-1:0] j;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && valid[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a sync FIFO.
// Define FIFO_ARB_BURST_EN to lock the grant for bursts.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_wen,
  output logic [DATA_W-1:0]           fifo_wdata,
  input  logic [CNT_W-1:0]            fifo_count,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_cfg
    $error("fifo_wr_arb: NUM_REQ out of range");
  end

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_oh;
  logic [CNT_W:0]     occ;
  logic               space_ok;
  logic               accept;

  // The write already in flight counts against free space
  assign occ      = {1'b0, fifo_count}
                  + {{CNT_W{1'b0}}, fifo_wen};
  assign space_ok = occ < (CNT_W+1)'(FIFO_DEPTH);

`ifdef FIFO_ARB_BURST_EN
  arb_state_e    state;
  logic [IW-1:0] owner;

  assign elig = (state == LOCK)
              ? (req_valid & (NUM_REQ'(1) << owner))
              : req_valid;
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign elig        = req_valid;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid  (elig),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign req_ready = (space_ok && !clear) ? pick_oh : '0;
  assign accept    = |(req_ready & req_valid);
  assign next_ptr  = (pick_idx == IW'(NUM_REQ - 1))
                   ? '0 : pick_idx + IW'(1);

  // Registered FIFO write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wen   <= 1'b0;
      fifo_wdata <= '0;
      grant_id   <= '0;
    end else if (clear) begin
      fifo_wen   <= 1'b0;
      fifo_wdata <= '0;
      grant_id   <= '0;
    end else begin
      fifo_wen <= accept;
      if (accept) begin
        fifo_wdata <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id   <= pick_idx;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  // Pointer and burst lock FSM; pointer frozen while locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      state  <= IDLE;
      owner  <= '0;
    end else if (clear) begin
      rr_ptr <= '0;
      state  <= IDLE;
      owner  <= '0;
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          if (req_last[pick_idx]) begin
            rr_ptr <= next_ptr;
          end else begin
            state <= LOCK;
            owner <= pick_idx;
          end
        end
        LOCK: begin
          if (req_last[pick_idx]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Pointer moves past each accepted winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (clear) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= next_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb (NUM_REQ=4, DATA_W=8).
// Burst scenario compiled only with FIFO_ARB_BURST_EN.
module tb_fifo_wr_arb;

  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [NR-1:0] req_valid;
  logic [31:0]   req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          fifo_wen;
  logic [7:0]    fifo_wdata;
  logic [5:0]    fifo_count;
  logic [1:0]    grant_id;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t ex;
  int   m_ptr;
  logic m_wen;
  logic m_lock;
  int   m_owner;
  int   last_w;

  fifo_wr_arb #(
    .NUM_REQ    (NR),
    .DATA_W     (8),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_count (fifo_count),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr   = 0;
    m_wen   = 1'b0;
    m_lock  = 1'b0;
    m_owner = 0;
    exp_q.delete();
  endtask

  // Sample ready, run the model for this cycle, step the clock
  task automatic tick(output logic [NR-1:0] obs,
                      output logic [NR-1:0] exp);
    logic [NR-1:0] elig;
    logic          space;
    int            w;
    int            j;
    exp_t          e;
    #1;
    obs   = req_ready;
    space = (int'(fifo_count) + int'(m_wen)) < DEPTH;
    elig  = req_valid;
`ifdef FIFO_ARB_BURST_EN
    if (m_lock) elig = req_valid & (NR'(1) << m_owner);
`endif
    exp = '0;
    w   = -1;
    if (space && !clear) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (w < 0 && elig[j]) w = j;
      end
    end
    last_w = w;
    if (w >= 0) begin
      exp[w] = 1'b1;
      e.g    = 2'(w);
      e.d    = req_data[w*8 +: 8];
      exp_q.push_back(e);
`ifdef FIFO_ARB_BURST_EN
      if (!m_lock) begin
        if (req_last[w]) m_ptr = (w + 1) % NR;
        else begin
          m_lock  = 1'b1;
          m_owner = w;
        end
      end else if (req_last[w]) begin
        m_lock = 1'b0;
        m_ptr  = (m_owner + 1) % NR;
      end
`else
      m_ptr = (w + 1) % NR;
`endif
    end
    m_wen = (w >= 0);
    if (clear) begin
      m_ptr   = 0;
      m_lock  = 1'b0;
      m_owner = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    clear      = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = 32'h3322_1100;
    fifo_count = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fifo_wen !== 1'b0) begin
      failures++;
      $display("FAIL reset_wen: got %b want 0", fifo_wen);
    end
    checks++;
    if (fifo_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_wdata: got %h want 00", fifo_wdata);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_grant: got %0d want 0", grant_id);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] o, e;
    int            seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    req_valid  = 4'hf;
    fifo_count = 6'd0;
    for (int c = 0; c < 8; c++) begin
      req_data = {8'h40 + 8'(c), 8'h30 + 8'(c),
                  8'h20 + 8'(c), 8'h10 + 8'(c)};
      tick(o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rr_ready: got %b want %b", o, e);
      end
      checks++;
      if (fifo_wen !== 1'b1) begin
        failures++;
        $display("FAIL rr_wen: got %b want 1", fifo_wen);
      end
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checks++;
        if (grant_id !== 2'(seq[c]) || ex.g !== 2'(seq[c])
            || fifo_wdata !== ex.d) begin
          failures++;
          $display("FAIL rr_out: got g%0d d%h want g%0d d%h",
                   grant_id, fifo_wdata, seq[c], ex.d);
        end
      end
    end
  endtask

  task automatic test_space();
    logic [NR-1:0] o, e;
    int            cnt[5] = '{31, 30, 30, 31, 32};
    req_valid = 4'hf;
    for (int c = 0; c < 5; c++) begin
      fifo_count = 6'(cnt[c]);
      tick(o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL space_ready: got %b want %b cnt %0d",
                 o, e, cnt[c]);
      end
      checks++;
      if (fifo_wen !== m_wen) begin
        failures++;
        $display("FAIL space_wen: got %b want %b", fifo_wen, m_wen);
      end
      if (m_wen && exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checks++;
        if (grant_id !== ex.g || fifo_wdata !== ex.d) begin
          failures++;
          $display("FAIL space_out: got g%0d d%h want g%0d d%h",
                   grant_id, fifo_wdata, ex.g, ex.d);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] o, e;
    logic [3:0]    vv[3] = '{4'b0100, 4'b0100, 4'b1111};
    int            gg[3] = '{2, 2, 3};
    fifo_count = 6'd0;
    for (int c = 0; c < 3; c++) begin
      req_valid = vv[c];
      req_data  = 32'hd3c2_b1a0 + 32'(c);
      tick(o, e);
      checks++;
      if (o !== e || last_w != gg[c]) begin
        failures++;
        $display("FAIL wrap_ready: got %b want %b (req %0d)",
                 o, e, gg[c]);
      end
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checks++;
        if (fifo_wen !== 1'b1 || grant_id !== 2'(gg[c])
            || fifo_wdata !== ex.d) begin
          failures++;
          $display("FAIL wrap_out: got g%0d d%h want g%0d d%h",
                   grant_id, fifo_wdata, gg[c], ex.d);
        end
      end
    end
  endtask

  task automatic test_clear();
    logic [NR-1:0] o, e;
    fifo_count = 6'd0;
    req_valid  = 4'b0010;
    tick(o, e);
    void'(exp_q.pop_front());
    req_valid = 4'hf;
    clear     = 1'b1;
    tick(o, e);
    clear = 1'b0;
    checks++;
    if (o !== 4'b0000) begin
      failures++;
      $display("FAIL clear_ready: got %b want 0000", o);
    end
    checks++;
    if (fifo_wen !== 1'b0) begin
      failures++;
      $display("FAIL clear_wen: got %b want 0", fifo_wen);
    end
    tick(o, e);
    checks++;
    if (o !== 4'b0001 || e !== 4'b0001) begin
      failures++;
      $display("FAIL clear_ptr: got %b want 0001", o);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst();
    logic [NR-1:0] o, e;
    int            gg[4] = '{1, 1, 1, 0};
    logic [3:0]    ll[4] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011};
    fifo_count = 6'd0;
    req_valid  = 4'b0001;
    req_last   = 4'b0001;
    tick(o, e);
    void'(exp_q.pop_front());
    req_valid = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      req_last = ll[c];
      req_data = 32'h0000_5000 + 32'(c * 16'h0101);
      tick(o, e);
      checks++;
      if (o !== e || last_w != gg[c]) begin
        failures++;
        $display("FAIL burst_ready: got %b want %b (req %0d)",
                 o, e, gg[c]);
      end
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checks++;
        if (grant_id !== 2'(gg[c]) || fifo_wdata !== ex.d) begin
          failures++;
          $display("FAIL burst_out: got g%0d d%h want g%0d d%h",
                   grant_id, fifo_wdata, gg[c], ex.d);
        end
      end
    end
    req_last = '0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [NR-1:0] o, e;
    for (int c = 0; c < 60; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      req_last   = 4'($urandom_range(0, 15));
      req_data   = $urandom;
      fifo_count = 6'($urandom_range(26, 32));
      tick(o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_ready: got %b want %b", o, e);
      end
      checks++;
      if (fifo_wen !== m_wen) begin
        failures++;
        $display("FAIL b2b_wen: got %b want %b", fifo_wen, m_wen);
      end
      if (m_wen && exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checks++;
        if (grant_id !== ex.g || fifo_wdata !== ex.d) begin
          failures++;
          $display("FAIL b2b_out: got g%0d d%h want g%0d d%h",
                   grant_id, fifo_wdata, ex.g, ex.d);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] o, e;
    fifo_count = 6'd0;
    req_valid  = 4'b0100;
    req_last   = '0;
    req_data   = 32'h0077_0000;
    tick(o, e);
    tick(o, e);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (fifo_wen !== 1'b0 || fifo_wdata !== 8'h00
        || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_out: got w%b d%h g%0d want w0 d00 g0",
               fifo_wen, fifo_wdata, grant_id);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'hf;
    req_last  = 4'hf;
    tick(o, e);
    checks++;
    if (o !== 4'b0001 || e !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_restart: got %b want 0001", o);
    end
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      checks++;
      if (fifo_wen !== 1'b1 || grant_id !== 2'd0
          || fifo_wdata !== ex.d) begin
        failures++;
        $display("FAIL rstmid_out2: got g%0d d%h want g0 d%h",
                 grant_id, fifo_wdata, ex.d);
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_round_robin();
    test_space();
    test_wrap();
    test_clear();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters; legal range 2..16.
REQ-002 Parameter DATA_W, default 8: payload width.
REQ-003 Parameter FIFO_DEPTH, default 32: entry count of the downstream sync FIFO.
REQ-004 Parameter CNT_W, default $clog2(FIFO_DEPTH)+1: width of the FIFO occupancy count.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 clear  in  1  synchronous flush; same effect as reset, one cycle.
REQ-008 req_valid  in  NUM_REQ  per-requester valid.
REQ-009 req_data  in  NUM_REQ x DATA_W  per-requester payload.
REQ-010 req_last  in  NUM_REQ  final beat of a burst; used only under FIFO_ARB_BURST_EN.
REQ-011 req_ready  out  NUM_REQ  one-hot beat accept.
REQ-012 fifo_wen  out  1  registered write enable to the FIFO.
REQ-013 fifo_wdata  out  DATA_W  registered write data.
REQ-014 fifo_count  in  CNT_W  FIFO occupancy, the FIFO's current-cycle count.
REQ-015 grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester, registered.

Function
REQ-016 A beat from requester i is accepted in cycle t iff req_valid[i] && req_ready[i]; at most one req_ready bit is high per cycle.
REQ-017 Space check: issue allowed iff fifo_count + fifo_wen < FIFO_DEPTH, computed at CNT_W+1 bits, so the registered write in flight is counted.
REQ-018 When issue is not allowed, req_ready is all-zero regardless of req_valid.
REQ-019 Round-robin: the winner is the first valid requester at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-020 After an accepted beat from winner w, rr_ptr becomes (w+1) mod NUM_REQ; without an accepted beat, rr_ptr holds.
REQ-021 An accepted beat appears at the outputs one cycle later: fifo_wen=1, fifo_wdata=req_data[w], grant_id=w.
REQ-022 In a cycle with no accepted beat, fifo_wen is 0 on the next cycle; fifo_wdata and grant_id hold.
REQ-023 req_ready is combinational from req_valid, rr_ptr, the FSM state and the space check; it does not depend on req_data.
REQ-024 Throughput: one beat per cycle while the space check passes.
REQ-025 A FIFO at FIFO_DEPTH-1 with fifo_wen=1 blocks further issue, so the FIFO is never written while full.
REQ-026 clear has priority over acceptance: req_ready=0 in the clear cycle; next cycle fifo_wen=0, rr_ptr=0, FSM=IDLE.

Reset
REQ-027 While rst_n=0: fifo_wen=0, fifo_wdata=0, grant_id=0, rr_ptr=0, FSM=IDLE, burst owner=0.
REQ-028 Reset asserted mid-burst discards the lock; an in-flight fifo_wen is dropped.

Configuration
REQ-029 Macro FIFO_ARB_BURST_EN defined: FSM with states IDLE and LOCK.
  - An accepted beat with req_last=0 moves IDLE->LOCK, owner=w.
  - In LOCK only the owner can get req_ready.
  - An accepted owner beat with req_last=1 moves LOCK->IDLE and advances rr_ptr to owner+1.
  - rr_ptr holds while in LOCK.
REQ-030 Macro undefined: no FSM and no owner register; req_last is ignored; each beat is arbitrated independently.

Structure
REQ-031 Package fifo_arb_pkg holds the arb_state_e enum (IDLE, LOCK) and the max-requester constant ARB_MAX_REQ=16.
REQ-032 Sub-module rr_pick (one-hot round-robin selector: valid vector and pointer in, one-hot and index out) is instantiated once.

Verification
REQ-033 Reset, then all four requesters valid continuously with fifo_count=0 -> fifo_wen stream with grant_id 0,1,2,3,0,... and one beat per cycle.
REQ-034 fifo_count=31 with fifo_wen=1 -> req_ready=0; fifo_count=30 with fifo_wen=0 -> exactly one beat accepted, then stall.
REQ-035 Only requester 2 valid, rr_ptr=3 -> wrap-around grants 2; rr_ptr becomes 3.
REQ-036 clear asserted in a cycle with requesters valid -> no accept that cycle; next cycle fifo_wen=0 and rr_ptr=0.
REQ-037 FIFO_ARB_BURST_EN: requester 1 sends a 3-beat burst (last on beat 3) while requester 0 is valid -> grants 1,1,1 then 0; no interleaving.
REQ-038 rst_n asserted mid-burst -> outputs at reset values; after release, arbitration restarts at requester 0.
